// File: rtl/seq_wide_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_wide_adder_ctrl_if
// Brief    : Request/response and external-adder signal bundle for the
//            multi-precision add/subtract sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_wide_adder_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
);
    localparam int N = WIDTH * WORDS;

    // Request side
    logic             clr;
    logic             req_valid;
    logic             req_ready;
    logic             Sub;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic             Ci;

    // Response side
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     S;
    logic             Co;
    logic             V;

    // Time-shared external adder
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_ci;
    logic [WIDTH-1:0] add_s;
    logic             add_co;

    // Requester issuing operations and consuming results
    modport master (
        output clr, req_valid, Sub, A, B, Ci, rsp_ready,
        input  req_ready, rsp_valid, S, Co, V
    );

    // Sequencer: owns all state and drives the adder operands
    modport slave (
        input  clr, req_valid, Sub, A, B, Ci, rsp_ready, add_s, add_co,
        output req_ready, rsp_valid, S, Co, V, add_a, add_b, add_ci
    );

    // Purely combinational WIDTH-bit adder
    modport adder (
        input  add_a, add_b, add_ci,
        output add_s, add_co
    );
endinterface
`default_nettype wire

// File: rtl/seq_wide_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_wide_adder_ctrl
// Brief    : Sequences a WIDTH*WORDS-bit add/subtract through one external
//            WIDTH-bit adder, one word per cycle, LSW first, with the carry
//            held in a register between words.
// Revision : 1.0 - initial release
// ============================================================================
module seq_wide_adder_ctrl #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    seq_wide_adder_ctrl_if.slave    bus
);

    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_RUN  = 2'd1,
        c_DONE = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;

    // Operands and result viewed as arrays of words
    logic [WORDS-1:0][WIDTH-1:0]  r_a;
    logic [WORDS-1:0][WIDTH-1:0]  r_b;
    logic [WORDS-1:0][WIDTH-1:0]  r_s;
    logic [CW-1:0]                r_cnt;
    logic                         r_carry;
    logic                         r_co;
    logic                         r_v;

    logic                         w_accept;
    logic                         w_last;

    // clr blocks an accept in the same cycle so a flushed request never starts
    assign w_accept = (r_state == c_IDLE) && bus.req_valid && !bus.clr;
    assign w_last   = (r_cnt == CW'(WORDS - 1));

    assign bus.S  = r_s;
    assign bus.Co = r_co;
    assign bus.V  = r_v;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, handshake outputs and adder operand steering
    always_comb begin
        w_next_state  = r_state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.add_a     = '0;
        bus.add_b     = '0;
        bus.add_ci    = 1'b0;
        case (r_state)
            c_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next_state = c_RUN;
                end
            end
            c_RUN: begin
                bus.add_a  = r_a[r_cnt];
                bus.add_b  = r_b[r_cnt];
                bus.add_ci = r_carry;
                if (w_last) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
        // Flush wins over every transition, including a DONE handshake
        if (bus.clr) begin
            w_next_state = c_IDLE;
        end
    end

    // Operand capture, per-word result write-back and carry chaining
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_v     <= 1'b0;
        end else if (bus.clr) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        // Subtraction is A + ~B + 1, so the incoming carry is forced
                        r_a     <= bus.A;
                        r_b     <= bus.Sub ? ~bus.B : bus.B;
                        r_carry <= bus.Sub ? 1'b1 : bus.Ci;
                        r_cnt   <= '0;
                    end
                end
                c_RUN: begin
                    r_s[r_cnt] <= bus.add_s;
                    r_carry    <= bus.add_co;
                    r_cnt      <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_co <= bus.add_co;
                        r_v  <= (bus.add_a[WIDTH-1] == bus.add_b[WIDTH-1]) &&
                                (bus.add_s[WIDTH-1] != bus.add_a[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_wide_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_wide_adder_ctrl
// Brief    : Directed-vector and golden-model bench for seq_wide_adder_ctrl
//            (WIDTH=8/WORDS=4 main instance, WIDTH=8/WORDS=1 side instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_wide_adder_ctrl;

    localparam int W = 8;
    localparam int K = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_wide_adder_ctrl_if #(.WIDTH(W), .WORDS(K)) bus  ();
    seq_wide_adder_ctrl_if #(.WIDTH(W), .WORDS(1)) bus1 ();

    seq_wide_adder_ctrl #(.WIDTH(W), .WORDS(K)) dut  (.clk(clk), .rst(rst), .bus(bus));
    seq_wide_adder_ctrl #(.WIDTH(W), .WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // External combinational adders
    assign {bus.add_co, bus.add_s}   = {1'b0, bus.add_a}  + {1'b0, bus.add_b}  + {8'd0, bus.add_ci};
    assign {bus1.add_co, bus1.add_s} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {8'd0, bus1.add_ci};

    typedef struct {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
        logic        v;
    } vec_t;

    vec_t vecs [8];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Golden result: {V, Co, S}
    function automatic logic [33:0] gold(input logic sub, input logic [31:0] a,
                                         input logic [31:0] b, input logic ci);
        logic [31:0] bb;
        logic [32:0] r;
        logic        v;
        bb = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : ci)};
        v  = (a[31] == bb[31]) && (r[31] != a[31]);
        return {v, r};
    endfunction

    // Issue one op on the main instance; returns in DONE at a negedge.
    // lat counts cycles from the accept cycle to the first cycle with rsp_valid.
    task automatic start_op(input logic sub, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, output int lat, output logic [3:0] cis);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.Sub = sub; bus.A = a; bus.B = b; bus.Ci = ci; bus.req_valid = 1'b1;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        lat = 0;
        cis = '0;
        do begin
            @(negedge clk);
            if (lat == 0) begin
                // operands must have been captured at accept
                bus.req_valid = 1'b0;
                bus.A = $urandom; bus.B = $urandom; bus.Sub = ~sub; bus.Ci = ~ci;
            end
            lat++;
            if (!bus.rsp_valid && lat <= 4) cis[lat-1] = bus.add_ci;
        end while (!bus.rsp_valid && lat < 20);
    endtask

    task automatic finish_op(input string nm);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({nm, "_idle_ready"}, {63'd0, bus.req_ready}, 64'd1);
        chk({nm, "_idle_rspv"},  {63'd0, bus.rsp_valid}, 64'd0);
    endtask

    initial begin
        int          lat;
        logic [3:0]  cis;
        logic [33:0] g;
        logic        seen;
        logic        sub;
        logic        ci;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};

        bus.clr = 0; bus.req_valid = 0; bus.Sub = 0; bus.A = 0; bus.B = 0; bus.Ci = 0; bus.rsp_ready = 0;
        bus1.clr = 0; bus1.req_valid = 0; bus1.Sub = 0; bus1.A = 0; bus1.B = 0; bus1.Ci = 0; bus1.rsp_ready = 0;

        // Reset values
        rst = 1'b1;
        #3;
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_S",         {32'd0, bus.S},         64'd0);
        chk("rst_Co_V",      {62'd0, bus.Co, bus.V}, 64'd0);
        chk("rst_adder",     {47'd0, bus.add_a, bus.add_b, bus.add_ci}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].ci, lat, cis);
            chk($sformatf("vec%0d_S", i),   {32'd0, bus.S},  {32'd0, vecs[i].s});
            chk($sformatf("vec%0d_Co", i),  {63'd0, bus.Co}, {63'd0, vecs[i].co});
            chk($sformatf("vec%0d_V", i),   {63'd0, bus.V},  {63'd0, vecs[i].v});
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd5);
            if (i == 0) chk("vec0_add_ci_seq", {60'd0, cis}, 64'hE);
            finish_op($sformatf("vec%0d", i));
        end

        // Backpressure: DONE held 10 cycles while inputs churn
        start_op(1'b0, 32'h11223344, 32'h01010101, 1'b0, lat, cis);
        for (int i = 0; i < 10; i++) begin
            bus.A = $urandom; bus.B = $urandom; bus.req_valid = ~bus.req_valid;
            @(negedge clk);
            chk($sformatf("bp_hold%0d", i), {29'd0, bus.S, bus.Co, bus.V, bus.req_ready, bus.rsp_valid},
                {29'd0, 32'h12233445, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        bus.req_valid = 1'b0;
        finish_op("bp");
        chk("bp_S_kept_idle", {32'd0, bus.S}, 64'h12233445);

        // Async reset with counter=2
        bus.Sub = 0; bus.A = 32'hFFFFFFFF; bus.B = 32'h1; bus.Ci = 0; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("arst_pre_ci", {63'd0, bus.add_ci}, 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_S",       {32'd0, bus.S}, 64'd0);
        chk("arst_handsh",  {62'd0, bus.req_ready, bus.rsp_valid}, 64'd2);
        chk("arst_adder",   {45'd0, bus.add_a, bus.add_b, bus.add_ci, bus.Co, bus.V}, 64'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_idle", {62'd0, bus.req_ready, bus.rsp_valid}, 64'd2);

        // clr during RUN discards the operation
        bus.Sub = 0; bus.A = 32'h01020304; bus.B = 32'h01010101; bus.Ci = 0; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("clr_no_rsp",   {63'd0, seen}, 64'd0);
        chk("clr_ready",    {63'd0, bus.req_ready}, 64'd1);
        start_op(vecs[6].sub, vecs[6].a, vecs[6].b, vecs[6].ci, lat, cis);
        chk("clr_next_S",   {32'd0, bus.S}, {32'd0, vecs[6].s});
        chk("clr_next_lat", 64'(lat), 64'd5);
        finish_op("clr_next");

        // WORDS=1 instance: 0xFF + 0x01
        bus1.A = 8'hFF; bus1.B = 8'h01; bus1.Sub = 0; bus1.Ci = 0; bus1.req_valid = 1'b1;
        chk("w1_ready", {63'd0, bus1.req_ready}, 64'd1);
        lat = 0;
        do begin
            @(negedge clk);
            bus1.req_valid = 1'b0;
            bus1.A = 8'h00;
            lat++;
        end while (!bus1.rsp_valid && lat < 20);
        chk("w1_S_Co_V", {54'd0, bus1.S, bus1.Co, bus1.V}, {54'd0, 8'h00, 1'b1, 1'b0});
        chk("w1_lat", 64'(lat), 64'd2);
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
        chk("w1_idle", {62'd0, bus1.req_ready, bus1.rsp_valid}, 64'd2);

        // Random regression against the golden model
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom;
            sub = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
            if (i % 7 == 0) b = ~a;
            if (i % 11 == 0) a = 32'h80000000;
            g = gold(sub, a, b, ci);
            start_op(sub, a, b, ci, lat, cis);
            chk($sformatf("rnd%0d_S", i),   {32'd0, bus.S},  {32'd0, g[31:0]});
            chk($sformatf("rnd%0d_CoV", i), {62'd0, bus.Co, bus.V}, {62'd0, g[32], g[33]});
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'd5);
            finish_op($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_wide_adder_ctrl.md
Name: seq_wide_adder_ctrl

Overview:
- Multi-precision add/subtract sequencer that time-shares one external WIDTH-bit ripple-carry adder across WORDS cycles.
- Produces a WIDTH*WORDS-bit result: one word per cycle, LSW first, carry held in a register between words.
- Sits between a request/response handshake and the adder instance. The adder stays purely combinational; this block owns all state.

Parameters:
- WIDTH, 32, adder width and word size in bits (>=1).
- WORDS, 4, number of words per operation (>=1); operand width N = WIDTH*WORDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous flush; aborts any operation and discards its result.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready; high only in IDLE.
- Sub  in  1  0: A+B+Ci; 1: A-B (Ci ignored).
- A  in  N  operand A.
- B  in  N  operand B.
- Ci  in  1  carry input (add only).
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted.
- S  out  N  sum/difference.
- Co  out  1  carry out; for Sub, 1 means no borrow.
- V  out  1  signed overflow.
- add_a  out  WIDTH  to adder A.
- add_b  out  WIDTH  to adder B.
- add_ci  out  1  to adder carry input.
- add_s  in  WIDTH  from adder sum.
- add_co  in  1  from adder carry output.

Behaviour:
- States: IDLE, RUN, DONE. Reset and clr both force IDLE.
- Reset values: req_ready=1, rsp_valid=0, S=0, Co=0, V=0, add_a=0, add_b=0, add_ci=0, word counter=0, carry register=0.
- IDLE to RUN on req_valid&&req_ready:
  - Latch A.
  - Latch B, or ~B when Sub=1.
  - Carry register = Sub ? 1 : Ci.
  - Counter = 0.
- RUN, word k = counter:
  - add_a = A word k; add_b = latched B word k; add_ci = carry register.
  - At the clock edge: write add_s into S word k, write add_co into the carry register, increment counter.
  - At k = WORDS-1, also: Co <= add_co; V <= (add_a[MSB]==add_b[MSB]) && (add_s[MSB]!=add_a[MSB]); go to DONE.
- Adder outputs are driven to 0 outside RUN.
- DONE: rsp_valid=1, and S/Co/V are held stable. On rsp_ready, go to IDLE.
- req_ready is 0 in RUN and DONE. req_valid is ignored there, so no accept can occur in the same cycle as a response handshake.
- Latency: accept edge to rsp_valid high is exactly WORDS+1 cycles. Minimum issue interval is WORDS+2 cycles.
- S is written only in RUN. It keeps its value across IDLE until the next operation overwrites it word by word.
- The adder path add_a/add_b to add_s/add_co is combinational through the external adder. It must close timing in one cycle; the block adds no retiming.
- WORDS=1: RUN lasts one cycle; identical rules apply.
- clr has priority over every transition, including a DONE handshake in the same cycle. A clr'd result is never presented.
- Async reset mid-RUN or mid-DONE: all outputs go to reset values immediately; the operation is lost.
- rsp_ready while not in DONE: ignored.
- Operand inputs are sampled only at accept. Later changes have no effect on an operation in flight.

Test Plan:
- Bench parameters WIDTH=8, WORDS=4 unless noted.
- Add carry ripple: A=0xFFFFFFFF, B=0x00000001, Ci=0, Sub=0 -> S=0x00000000, Co=1, V=0. rsp_valid exactly 5 cycles after accept; add_ci observed 0,1,1,1 per RUN cycle.
- Subtract with borrow: A=0x00000000, B=0x00000001, Sub=1 -> S=0xFFFFFFFF, Co=0, V=0. Second case A=5, B=3 -> S=2, Co=1.
- Overflow: A=0x7FFFFFFF, B=0x00000001, Ci=0 -> S=0x80000000, Co=0, V=1. Add-with-Ci case: A=0, B=0, Ci=1 -> S=1.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE and toggle A/B/req_valid -> S/Co/V stable, req_ready=0, no new accept. rsp_ready=1 -> IDLE next cycle, req_ready=1.
- Abort/reset:
  - Assert rst asynchronously with counter=2 -> all outputs at reset values before the next edge, state IDLE.
  - Separately, clr during RUN -> no rsp_valid; next request completes correctly.
- WORDS=1, WIDTH=8: 0xFF+0x01 -> S=0x00, Co=1, rsp_valid 2 cycles after accept. Random 1000-op regression against a golden model at default parameters.
